ex_stage: RTL

Execute stage of the 5-stage pipeline. It consumes the OF/EX latch outputs (PC, branch target, operands A/B/2, IR, 22-bit control bus) and drives the EX/MA latch. It performs single-cycle ALU ops, holds the cmp flags, and resolves branches. Signed div/mod runs on a 32-iteration sequential divider, and the stage holds the upstream pipeline through `EX_stall` while it runs.

---
 rtl/ex_pkg.sv | 42 ++++
 rtl/ex_stage_if.sv | 36 +++
 rtl/ex_divider.sv | 82 ++++++++
 rtl/ex_stage.sv | 90 +++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants, control-bit indices and divider state type for the execute stage
package ex_pkg;

   localparam int WIDTH     = 32;
   localparam int CTRL_W    = 22;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 5;

   localparam int IS_ST      = 0;
   localparam int IS_LD      = 1;
   localparam int IS_BEQ     = 2;
   localparam int IS_BGT     = 3;
   localparam int IS_RET     = 4;
   localparam int IS_IMM     = 5;
   localparam int IS_WB      = 6;
   localparam int IS_UBRANCH = 7;
   localparam int IS_CALL    = 8;
   localparam int IS_ADD     = 9;
   localparam int IS_SUB     = 10;
   localparam int IS_CMP     = 11;
   localparam int IS_MUL     = 12;
   localparam int IS_DIV     = 13;
   localparam int IS_MOD     = 14;
   localparam int IS_LSL     = 15;
   localparam int IS_LSR     = 16;
   localparam int IS_ASR     = 17;
   localparam int IS_OR      = 18;
   localparam int IS_AND     = 19;
   localparam int IS_NOT     = 20;
   localparam int IS_MOV     = 21;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - OF/EX latch inputs and EX/MA latch outputs of the execute stage
interface ex_stage_if;
   import ex_pkg::*;

   logic [WIDTH-1:0]  input_EX_PC;
   logic [WIDTH-1:0]  EX_branchTarget;
   logic [WIDTH-1:0]  Operand_EX_A;
   logic [WIDTH-1:0]  Operand_EX_B;
   logic [WIDTH-1:0]  Operand_EX_2;
   logic [WIDTH-1:0]  input_EX_IR;
   logic [CTRL_W-1:0] Input_EX_controlBus;

   logic [WIDTH-1:0]  output_EX_ALUResult;
   logic              EX_isBranchTaken;
   logic [WIDTH-1:0]  EX_branchPC;
   logic              EX_stall;
   logic [WIDTH-1:0]  output_EX_PC;
   logic [WIDTH-1:0]  output_EX_Operand2;
   logic [WIDTH-1:0]  output_EX_IR;
   logic [CTRL_W-1:0] output_EX_controlBus;

   modport master (
      output input_EX_PC, EX_branchTarget, Operand_EX_A, Operand_EX_B,
             Operand_EX_2, input_EX_IR, Input_EX_controlBus,
      input  output_EX_ALUResult, EX_isBranchTaken, EX_branchPC, EX_stall,
             output_EX_PC, output_EX_Operand2, output_EX_IR, output_EX_controlBus
   );

   modport slave (
      input  input_EX_PC, EX_branchTarget, Operand_EX_A, Operand_EX_B,
             Operand_EX_2, input_EX_IR, Input_EX_controlBus,
      output output_EX_ALUResult, EX_isBranchTaken, EX_branchPC, EX_stall,
             output_EX_PC, output_EX_Operand2, output_EX_IR, output_EX_controlBus
   );

endinterface

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - 32-step restoring signed divider producing quotient and remainder
module ex_divider
   import ex_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o
);

   div_state_e       state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvsr_q;
   logic [WIDTH-1:0] quo_d, rem_d;
   logic             neg_quo_q, neg_rem_q, div_zero_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr_q};
   assign fits    = (shifted >= {1'b0, dvsr_q});
   assign rem_d   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_d   = {quo_q[WIDTH-2:0], fits};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  quo_q      <= magnitude(dividend_i);
                  rem_q      <= '0;
                  dvsr_q     <= magnitude(divisor_i);
                  neg_quo_q  <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                  neg_rem_q  <= dividend_i[WIDTH-1];
                  div_zero_q <= (divisor_i == '0);
                  count_q    <= '0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               quo_q   <= quo_d;
               rem_q   <= rem_d;
               count_q <= count_q + 1'b1;
               if (count_q == CNT_W'(DIV_ITERS - 1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = (state_q == BUSY);
   assign done_o = (state_q == DONE);

   // Divide by zero leaves |A| in the remainder, so only the quotient needs forcing.
   assign quo_o = div_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
   assign rem_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, compare flags, branch resolution and div/mod stall control
module ex_stage
   import ex_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   ex_stage_if.slave bus
);

   logic [CTRL_W-1:0] ctrl;
   logic [WIDTH-1:0]  op_a, op_b;
   logic [4:0]        shamt;
   logic [WIDTH-1:0]  alu_res;
   logic [WIDTH-1:0]  div_quo, div_rem;
   logic              div_start, div_busy, div_done;
   logic              ex_stall;
   logic              e_q, gt_q, e_d, gt_d;

   assign ctrl  = bus.Input_EX_controlBus;
   assign op_a  = bus.Operand_EX_A;
   assign op_b  = bus.Operand_EX_B;
   assign shamt = op_b[4:0];

   // Low half of a product is identical for signed and unsigned operands.
   always_comb begin
      alu_res = '0;
      if (ctrl[IS_ADD] | ctrl[IS_LD] | ctrl[IS_ST]) begin
         alu_res = op_a + op_b;
      end else if (ctrl[IS_SUB] | ctrl[IS_CMP]) begin
         alu_res = op_a - op_b;
      end else if (ctrl[IS_MUL]) begin
         alu_res = op_a * op_b;
      end else if (ctrl[IS_LSL]) begin
         alu_res = op_a << shamt;
      end else if (ctrl[IS_LSR]) begin
         alu_res = op_a >> shamt;
      end else if (ctrl[IS_ASR]) begin
         alu_res = $signed(op_a) >>> shamt;
      end else if (ctrl[IS_OR]) begin
         alu_res = op_a | op_b;
      end else if (ctrl[IS_AND]) begin
         alu_res = op_a & op_b;
      end else if (ctrl[IS_NOT]) begin
         alu_res = ~op_b;
      end else if (ctrl[IS_MOV]) begin
         alu_res = op_b;
      end
   end

   assign e_d  = (op_a == op_b);
   assign gt_d = ($signed(op_a) > $signed(op_b));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q  <= 1'b0;
         gt_q <= 1'b0;
      end else if (ctrl[IS_CMP] && !ex_stall) begin
         e_q  <= e_d;
         gt_q <= gt_d;
      end
   end

   assign div_start = ctrl[IS_DIV] | ctrl[IS_MOD];

   ex_divider u_divider (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (op_a),
      .divisor_i  (op_b),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quo_o      (div_quo),
      .rem_o      (div_rem)
   );

   // Stall covers the IDLE decode cycle and all BUSY cycles; DONE lets the latches advance.
   assign ex_stall = rst_n & (div_busy | (div_start & ~div_busy & ~div_done));

   assign bus.EX_stall            = ex_stall;
   assign bus.output_EX_ALUResult = div_done ? (ctrl[IS_MOD] ? div_rem : div_quo) : alu_res;
   assign bus.EX_isBranchTaken    = ctrl[IS_UBRANCH] | (ctrl[IS_BEQ] & e_q) | (ctrl[IS_BGT] & gt_q);
   assign bus.EX_branchPC         = ctrl[IS_RET] ? op_a : bus.EX_branchTarget;

   assign bus.output_EX_PC         = bus.input_EX_PC;
   assign bus.output_EX_Operand2   = bus.Operand_EX_2;
   assign bus.output_EX_IR         = bus.input_EX_IR;
   assign bus.output_EX_controlBus = ctrl;

endmodule
